// File: rtl/pulse_period_meter.sv
// Measures enabled ticks between rising edges of i_pulse; reports period, lock and overflow.
// Optional input synchroniser enabled by defining PULSE_METER_SYNC_EN.
module pulse_period_meter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_count_enbl,
  input  logic             i_pulse,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_period,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_overflow
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0] LockMax = MW'(LOCK_CNT);
  localparam logic [WIDTH-1:0] MaxCnt = {WIDTH{1'b1}};

  typedef enum logic [1:0] {StIdle, StMeasure, StOvf} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [MW-1:0]    match_q, match_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             ovf_q, ovf_d;
  logic             p, p_q, rise;
  logic [WIDTH:0]   val;
  logic [MW-1:0]    match_new;

`ifdef PULSE_METER_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], i_pulse};
  end
  assign p = sync_q[1];
`else
  assign p = i_pulse;
`endif

  assign rise = p & ~p_q;
  // Extra bit flags an interval that no longer fits in WIDTH bits.
  assign val  = {1'b0, cnt_q} + {{WIDTH{1'b0}}, i_count_enbl};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    ref_d     = ref_q;
    match_d   = match_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    ovf_d     = ovf_q;
    match_new = match_q;

    if (i_clear) begin
      state_d  = StIdle;
      cnt_d    = '0;
      locked_d = 1'b0;
      ovf_d    = 1'b0;
      match_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            state_d = StMeasure;
            cnt_d   = '0;
          end
        end
        StMeasure: begin
          if (rise) begin
            cnt_d = '0;
            if (val[WIDTH]) begin
              ovf_d    = 1'b1;
              match_d  = '0;
              locked_d = 1'b0;
            end else begin
              period_d = val[WIDTH-1:0];
              valid_d  = 1'b1;
              ovf_d    = 1'b0;
              if (match_q == '0 || val[WIDTH-1:0] != ref_q) begin
                ref_d     = val[WIDTH-1:0];
                match_new = MW'(1);
              end else if (match_q < LockMax) begin
                match_new = match_q + MW'(1);
              end
              match_d  = match_new;
              locked_d = (match_new >= LockMax);
            end
          end else if (i_count_enbl) begin
            if (cnt_q == MaxCnt) begin
              state_d  = StOvf;
              ovf_d    = 1'b1;
              match_d  = '0;
              locked_d = 1'b0;
            end else begin
              cnt_d = cnt_q + WIDTH'(1);
            end
          end
        end
        StOvf: begin
          if (rise) begin
            state_d = StMeasure;
            cnt_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      period_q <= '0;
      ref_q    <= '0;
      match_q  <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
      p_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      ref_q    <= ref_d;
      match_q  <= match_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      ovf_q    <= ovf_d;
      p_q      <= p;
    end
  end

  assign o_period   = period_q;
  assign o_valid    = valid_q;
  assign o_locked   = locked_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter (WIDTH=4, LOCK_CNT=4) plus a LOCK_CNT=1 instance.
module tb_pulse_period_meter;

`ifdef PULSE_METER_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_count_enbl;
  logic       i_pulse;
  logic       i_clear;
  logic [3:0] o_period, o_period1;
  logic       o_valid, o_locked, o_overflow;
  logic       o_valid1, o_locked1, o_overflow1;

  int   tests = 0;
  int   fails = 0;
  int   pend  = 0;
  int   mode  = 0;  // 0: enable high, 1: alternate, 2: enable low
  logic tog   = 1'b0;
  logic lk1   = 1'b0;

  pulse_period_meter #(.WIDTH(4), .LOCK_CNT(4)) u_dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_count_enbl (i_count_enbl),
    .i_pulse      (i_pulse),
    .i_clear      (i_clear),
    .o_period     (o_period),
    .o_valid      (o_valid),
    .o_locked     (o_locked),
    .o_overflow   (o_overflow)
  );

  pulse_period_meter #(.WIDTH(4), .LOCK_CNT(1)) u_dut1 (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_count_enbl (i_count_enbl),
    .i_pulse      (i_pulse),
    .i_clear      (i_clear),
    .o_period     (o_period1),
    .o_valid      (o_valid1),
    .o_locked     (o_locked1),
    .o_overflow   (o_overflow1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    tog = ~tog;
    case (mode)
      0:       i_count_enbl = 1'b1;
      1:       i_count_enbl = tog;
      default: i_count_enbl = 1'b0;
    endcase
    @(posedge clk);
    #1;
  endtask

  // Rise gap edges after the previous one; ep < 0 skips the period compare.
  task automatic edge_after(input int gap, input int ev, input int ep, input int el, input int eo,
                            input string tag);
    int lows;
    lows = gap - 1 - pend;
    i_pulse = 1'b0;
    for (int i = 0; i < lows; i++) step();
    i_pulse = 1'b1;
    step();
    i_pulse = 1'b0;
    for (int i = 0; i < Lat; i++) step();
    check({tag, ".valid"}, 32'(o_valid), 32'(ev));
    if (ev != 0 && ep >= 0) check({tag, ".period"}, 32'(o_period), 32'(ep));
    check({tag, ".locked"}, 32'(o_locked), 32'(el));
    check({tag, ".ovf"}, 32'(o_overflow), 32'(eo));
    lk1 = (ev != 0) ? 1'b1 : ((eo != 0) ? 1'b0 : lk1);
    check({tag, ".locked1"}, 32'(o_locked1), 32'(lk1));
    step();
    check({tag, ".valid_drop"}, 32'(o_valid), 32'd0);
    pend = Lat + 1;
  endtask

  task automatic clear_on_rise(input int gap, input int held_period);
    int lows;
    lows = gap - 1 - pend;
    for (int i = 0; i < lows; i++) step();
    for (int j = 0; j <= Lat; j++) begin
      i_pulse = (j == 0);
      i_clear = (j == Lat);
      step();
    end
    i_pulse = 1'b0;
    i_clear = 1'b0;
    lk1 = 1'b0;
    check("clr.valid", 32'(o_valid), 32'd0);
    check("clr.locked", 32'(o_locked), 32'd0);
    check("clr.locked1", 32'(o_locked1), 32'd0);
    check("clr.ovf", 32'(o_overflow), 32'd0);
    check("clr.period_hold", 32'(o_period), 32'(held_period));
    step();
    pend = Lat + 1;
  endtask

  task automatic pulse_reset(input string tag);
    #2 i_rst_n = 1'b0;
    #1;
    check({tag, ".period"}, 32'(o_period), 32'd0);
    check({tag, ".valid"}, 32'(o_valid), 32'd0);
    check({tag, ".locked"}, 32'(o_locked), 32'd0);
    check({tag, ".ovf"}, 32'(o_overflow), 32'd0);
    lk1 = 1'b0;
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
    pend = 0;
  endtask

  initial begin
    i_rst_n      = 1'b1;
    i_count_enbl = 1'b1;
    i_pulse      = 1'b0;
    i_clear      = 1'b0;
    #1 i_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.period", 32'(o_period), 32'd0);
    check("rst.valid", 32'(o_valid), 32'd0);
    check("rst.locked", 32'(o_locked), 32'd0);
    check("rst.ovf", 32'(o_overflow), 32'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Steady stream of 5: reference edge, then lock on the 4th valid.
    edge_after(5, 0, -1, 0, 0, "ref");
    edge_after(5, 1, 5, 0, 0, "p5a");
    edge_after(5, 1, 5, 0, 0, "p5b");
    edge_after(5, 1, 5, 0, 0, "p5c");
    edge_after(5, 1, 5, 1, 0, "p5d");

    // One interval of 7 breaks lock; four more 5s restore it.
    edge_after(7, 1, 7, 0, 0, "p7");
    edge_after(5, 1, 5, 0, 0, "r5a");
    edge_after(5, 1, 5, 0, 0, "r5b");
    edge_after(5, 1, 5, 0, 0, "r5c");
    edge_after(5, 1, 5, 1, 0, "r5d");

    // Clear coinciding with a rise while locked.
    clear_on_rise(5, 5);
    edge_after(5, 0, -1, 0, 0, "clr_ref");
    edge_after(5, 1, 5, 0, 0, "clr_p5");

    // Width boundary: 15 fits, 16 overflows at the rise, 20 enters the overflow state.
    edge_after(15, 1, 15, 0, 0, "max15");
    edge_after(16, 0, -1, 0, 1, "ovf16");
    edge_after(6, 1, 6, 0, 0, "after16");
    edge_after(20, 0, -1, 0, 1, "ovf20");
    edge_after(6, 1, 6, 0, 0, "after20");

    // Enable every other cycle: 10 cycles yield 5 ticks.
    mode = 1;
    edge_after(10, 1, -1, 0, 0, "alt_prime");
    edge_after(10, 1, 5, 0, 0, "alt_a");
    edge_after(10, 1, 5, 0, 0, "alt_b");

    // No enabled tick between two rises reports a zero period.
    mode = 2;
    edge_after(2 + Lat, 1, -1, 0, 0, "zero_prime");
    edge_after(2 + Lat, 1, 0, 0, 0, "zero");

    // Asynchronous reset mid-interval, then from the overflow state.
    mode = 0;
    edge_after(6, 1, -1, 0, 0, "recount");
    check("pre_rst.period_nonzero", 32'(o_period != 4'd0), 32'd1);
    repeat (3) step();
    pulse_reset("rst_mid");
    edge_after(5, 0, -1, 0, 0, "rst_ref");
    repeat (18) step();
    check("ovf_state.ovf", 32'(o_overflow), 32'd1);
    check("ovf_state.valid", 32'(o_valid), 32'd0);
    pulse_reset("rst_ovf");
    edge_after(5, 0, -1, 0, 0, "rst2_ref");
    edge_after(5, 1, 5, 0, 0, "rst2_p5");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
